// File: rtl/uart_matrix_loader.sv
// Parses ASCII hex tokens from the UART receive stream and writes each token as
// one SRAM word, filling N_MAT square matrices in column-major order.
module uart_matrix_loader #(
  parameter int M_SIZE     = 4,
  parameter int N_MAT      = 2,
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_DIGITS = 4,
  localparam int TOTAL     = N_MAT * M_SIZE * M_SIZE,
  localparam int WC_W      = $clog2(TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_error,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WC_W-1:0]       word_count,
  output logic [1:0]            dbg_state
);

  localparam int ACC_W = 4 * MAX_DIGITS;
  localparam int DC_W  = $clog2(MAX_DIGITS + 1);
  localparam logic [ADDR_WIDTH-1:0] M_A  = ADDR_WIDTH'(M_SIZE);
  localparam logic [ADDR_WIDTH-1:0] MM_A = ADDR_WIDTH'(M_SIZE * M_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  // Input handshake: rx_valid is a single-cycle qualifier for rx_byte with no
  // backpressure; every accepted byte is fully handled in the cycle it arrives.

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DC_W-1:0]       dig_q, dig_d;
  logic [WC_W-1:0]       wc_q, wc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                  is_hex, is_sep;
  logic [3:0]            nibble;
  logic [ADDR_WIDTH-1:0] w_a, word_addr;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
    is_sep = (rx_byte == 8'h20) || (rx_byte == 8'h09) || (rx_byte == 8'h2C) ||
             (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  end

  // Text arrives row-major; the multiply engine reads each matrix column-major.
  always_comb begin
    w_a       = ADDR_WIDTH'(wc_q);
    word_addr = (w_a / MM_A) * MM_A + (w_a % M_A) * M_A + (w_a % MM_A) / M_A;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dig_d   = dig_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (start) begin
      state_d = LOAD;
      acc_d   = '0;
      dig_d   = '0;
      wc_d    = '0;
    end else if (state_q == LOAD) begin
      if (rx_error) begin
        state_d = ERROR;
        acc_d   = '0;
        dig_d   = '0;
      end else if (rx_valid) begin
        if (is_hex) begin
          if (dig_q < DC_W'(MAX_DIGITS)) begin
            acc_d = {acc_q[ACC_W-5:0], nibble};
            dig_d = dig_q + DC_W'(1);
          end else begin
            state_d = ERROR;
            acc_d   = '0;
            dig_d   = '0;
          end
        end else if (is_sep) begin
          if (dig_q != '0) begin
            we_d   = 1'b1;
            addr_d = word_addr;
            data_d = DATA_WIDTH'(acc_q);
            wc_d   = wc_q + WC_W'(1);
            acc_d  = '0;
            dig_d  = '0;
            if (wc_q + WC_W'(1) == WC_W'(TOTAL)) state_d = DONE;
          end
        end else begin
          state_d = ERROR;
          acc_d   = '0;
          dig_d   = '0;
        end
      end
    end
    busy_d = (state_d == LOAD);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dig_q   <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dig_q   <= dig_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_data  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Bench for uart_matrix_loader: table vectors, hand sequences and random bytes,
// all scored against a token-level reference model.
module tb_uart_matrix_loader;

  localparam int M      = 4;
  localparam int NM     = 2;
  localparam int DW     = 18;
  localparam int AW     = 11;
  localparam int MAXD   = 4;
  localparam int TOTAL  = NM * M * M;
  localparam int WC_W   = $clog2(TOTAL + 1);

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_DONE = 2;
  localparam int S_ERR  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, rx_valid, rx_error;
  logic [7:0]    rx_byte;
  logic          sram_we, busy, done, err;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic [WC_W-1:0] word_count;
  logic [1:0]    dbg_state;

  uart_matrix_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_error(rx_error), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_data(sram_data), .busy(busy), .done(done),
    .err(err), .word_count(word_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [AW+DW-1:0] exp_q[$];
  int m_state, m_dig, m_val, m_wc;
  int last_addr, last_data;
  int n_writes;
  int mem_seen[0:63];

  typedef struct {
    string name;
    string text;
    int    writes;
    int    busy;
    int    done;
    int    err;
    int    wc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic bit is_sep(input logic [7:0] b);
    return b == 8'h20 || b == 8'h09 || b == 8'h2C || b == 8'h0D || b == 8'h0A;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_dig = 0; m_val = 0; m_wc = 0;
    last_addr = 0; last_data = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic st, input logic v, input logic [7:0] b,
                            input logic e);
    int h, n, r, c;
    if (st) begin
      m_state = S_LOAD; m_dig = 0; m_val = 0; m_wc = 0;
    end else if (m_state == S_LOAD) begin
      h = hex_val(b);
      if (e) m_state = S_ERR;
      else if (v) begin
        if (h >= 0) begin
          if (m_dig < MAXD) begin
            m_val = m_val * 16 + h;
            m_dig++;
          end else m_state = S_ERR;
        end else if (is_sep(b)) begin
          if (m_dig > 0) begin
            n = m_wc / (M * M);
            r = (m_wc % (M * M)) / M;
            c = m_wc % M;
            exp_q.push_back({AW'(n * M * M + c * M + r), DW'(m_val)});
            m_wc++;
            m_val = 0; m_dig = 0;
            if (m_wc == TOTAL) m_state = S_DONE;
          end
        end else m_state = S_ERR;
      end
    end
  endtask

  task automatic check_outputs();
    logic [AW+DW-1:0] e;
    if (sram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 sram_addr, sram_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", sram_addr, e[AW+DW-1:DW]);
        chk("write_data", sram_data, e[DW-1:0]);
      end
      last_addr = int'(sram_addr);
      last_data = int'(sram_data);
      if (sram_addr < 64) mem_seen[sram_addr] = int'(sram_data);
      n_writes++;
    end else begin
      chk("hold_addr", sram_addr, last_addr);
      chk("hold_data", sram_data, last_data);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_write: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    chk("busy", busy, m_state == S_LOAD);
    chk("done", done, m_state == S_DONE);
    chk("err", err, m_state == S_ERR);
    chk("word_count", word_count, m_wc);
  endtask

  task automatic drive_cycle(input logic st, input logic v, input logic [7:0] b,
                             input logic e);
    start = st; rx_valid = v; rx_byte = b; rx_error = e;
    model_step(st, v, b, e);
    @(posedge clk);
    #1;
    start = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
    check_outputs();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive_cycle(1'b0, 1'b1, s[i], 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, sram_we, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_data"}, sram_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int n0;
    int k;
    string hex_chars;
    logic [7:0] seps[5];
    logic [7:0] b;
    logic st, v, e;

    hex_chars = "0123456789abcdefABCDEF";
    seps[0] = 8'h20; seps[1] = 8'h09; seps[2] = 8'h2C; seps[3] = 8'h0D; seps[4] = 8'h0A;
    vecs[0] = '{"two_tokens", "1A 2\r\n",      2, 1, 0, 0, 2};
    vecs[1] = '{"overlong",   "ffff,12345 ",   1, 0, 0, 1, 1};
    vecs[2] = '{"bad_char",   "3g",            0, 0, 0, 1, 0};
    vecs[3] = '{"multi_sep",  "7  ,\r\n8 ",    2, 1, 0, 0, 2};
    vecs[4] = '{"unterm",     "abc",           0, 1, 0, 0, 0};
    for (int i = 0; i < 64; i++) mem_seen[i] = -1;
    n_writes = 0;

    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    send_str("1 2 ");

    for (int i = 0; i < 5; i++) begin
      n0 = n_writes;
      drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
      send_str(vecs[i].text);
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
      chk({vecs[i].name, "_writes"}, n_writes - n0, vecs[i].writes);
      chk({vecs[i].name, "_busy"}, busy, vecs[i].busy);
      chk({vecs[i].name, "_done"}, done, vecs[i].done);
      chk({vecs[i].name, "_err"}, err, vecs[i].err);
      chk({vecs[i].name, "_wc"}, word_count, vecs[i].wc);
    end

    for (int i = 0; i < 64; i++) mem_seen[i] = -1;
    n0 = n_writes;
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int t = 0; t < TOTAL; t++) send_str($sformatf("%0h ", t));
    chk("full_writes", n_writes - n0, 32);
    chk("full_done", done, 1);
    chk("full_wc", word_count, 32);
    chk("full_addr4", mem_seen[4], 32'h01);
    chk("full_addr5", mem_seen[5], 32'h05);
    chk("full_addr16", mem_seen[16], 32'h10);
    chk("full_addr31", mem_seen[31], 32'h1F);
    n0 = n_writes;
    send_str("5 6 ");
    chk("after_done_writes", n_writes - n0, 0);
    chk("after_done_done", done, 1);

    n0 = n_writes;
    drive_cycle(1'b1, 1'b1, 8'h39, 1'b0);
    send_str(" ");
    chk("start_drops_writes", n_writes - n0, 0);
    chk("start_drops_wc", word_count, 0);
    send_str("4");
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    send_str(" ");
    chk("rx_error_writes", n_writes - n0, 0);
    chk("rx_error_err", err, 1);

    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send_str("3");
    rx_valid = 1'b1; rx_byte = 8'h20;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_we_now", sram_we, 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check_all_zero("mid_reset");
    #3;
    reset_n = 1'b1;
    n0 = n_writes;
    send_str("1 2 ");
    chk("post_reset_writes", n_writes - n0, 0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_state != S_LOAD) st = ($urandom_range(0, 9) == 0);
      else st = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 2) != 0);
      k = $urandom_range(0, 99);
      if (k < 60) b = hex_chars[$urandom_range(0, 21)];
      else if (k < 92) b = seps[$urandom_range(0, 4)];
      else b = 8'($urandom_range(0, 255));
      drive_cycle(st, v, b, e);
    end

    drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
